// File: rtl/sdram_arb_pkg.sv
// Shared types and width defaults for the SDRAM request arbiter.
package sdram_arb_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int LEN_W_DEF  = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WAIT_WR,
    S_RD,
    S_WAIT_RD
  } state_t;

endpackage

// File: rtl/sdram_addr_gen.sv
// Burst start-address generator: ack falling-edge advance, window wrap, load-restart.
// Optional build macro SDRAM_PINGPONG_EN: MSB becomes a ping-pong bank bit.
module sdram_addr_gen
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ack,
  input  logic              load,
  input  logic              idle,
  input  logic              wait_st,
  input  logic [LEN_W-1:0]  burst,
  input  logic [ADDR_W-1:0] min_addr,
  input  logic [ADDR_W-1:0] max_addr,
`ifdef SDRAM_PINGPONG_EN
  input  logic              wrap_bank,
`endif
  output logic [ADDR_W-1:0] addr,
  output logic              pend,
  output logic              done
);

  localparam int SW = ADDR_W + 1;

  logic          ack_q;
  logic          load_q;
  logic [SW-1:0] sum;
  logic          wrap;
  logic [ADDR_W-1:0] adv_addr;

  assign done = wait_st & ack_q & ~ack;

`ifdef SDRAM_PINGPONG_EN
  // Window compare ignores the bank bit; a wrap flips to the bank chosen by the top.
  always_comb begin
    sum      = SW'(addr[ADDR_W-2:0]) + SW'(burst);
    wrap     = (sum >= SW'(max_addr[ADDR_W-2:0]));
    adv_addr = wrap ? {wrap_bank, min_addr[ADDR_W-2:0]}
                    : {addr[ADDR_W-1], sum[ADDR_W-2:0]};
  end
`else
  always_comb begin
    sum      = SW'(addr) + SW'(burst);
    wrap     = (sum >= SW'(max_addr));
    adv_addr = wrap ? min_addr : sum[ADDR_W-1:0];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= 1'b0;
      load_q <= 1'b0;
      pend   <= 1'b0;
      addr   <= '0;
    end else begin
      ack_q  <= ack;
      load_q <= load;
      if (load && !load_q)
        pend <= 1'b1;
      else if (idle && pend)
        pend <= 1'b0;
      // A load that arrived mid-burst overrides the advance of that burst.
      if (done)
        addr <= pend ? min_addr : adv_addr;
      else if (idle && pend)
        addr <= min_addr;
    end
  end

endmodule

// File: rtl/sdram_req_arb.sv
// SDRAM upstream arbiter: issues burst write/read requests from FIFO levels.
// Optional build macro SDRAM_PINGPONG_EN enables write/read bank ping-pong.
module sdram_req_arb
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int USE_W     = 11,
  parameter int RDF_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdram_init_done,
  input  logic [USE_W-1:0]  wrf_use,
  input  logic [USE_W-1:0]  rdf_use,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] wr_min_addr,
  input  logic [ADDR_W-1:0] wr_max_addr,
  input  logic [ADDR_W-1:0] rd_min_addr,
  input  logic [ADDR_W-1:0] rd_max_addr,
  input  logic [LEN_W-1:0]  wr_burst,
  input  logic [LEN_W-1:0]  rd_burst,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  output logic [ADDR_W-1:0] sdram_wr_addr,
  output logic [ADDR_W-1:0] sdram_rd_addr
);

  localparam int CW = USE_W + LEN_W + 1;

  state_t state, state_nxt;
  logic   wr_pend, rd_pend, wr_done, rd_done;
  logic   wr_go, rd_go, st_idle;

  assign wr_go   = (wr_burst != '0) && (CW'(wrf_use) >= CW'(wr_burst));
  assign rd_go   = rd_valid && (rd_burst != '0) &&
                   ((CW'(rdf_use) + CW'(rd_burst)) <= CW'(RDF_DEPTH));
  assign st_idle = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    sdram_wr_req = 1'b0;
    sdram_rd_req = 1'b0;
    case (state)
      S_IDLE: begin
        // A pending load costs one idle cycle before any request.
        if (sdram_init_done && !wr_pend && !rd_pend) begin
          if (wr_go)      state_nxt = S_WR;
          else if (rd_go) state_nxt = S_RD;
        end
      end
      S_WR: begin
        sdram_wr_req = 1'b1;
        if (sdram_wr_ack) state_nxt = S_WAIT_WR;
      end
      S_WAIT_WR: if (wr_done) state_nxt = S_IDLE;
      S_RD: begin
        sdram_rd_req = 1'b1;
        if (sdram_rd_ack) state_nxt = S_WAIT_RD;
      end
      S_WAIT_RD: if (rd_done) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

`ifdef SDRAM_PINGPONG_EN
  // Write wraps flip the write bank; read wraps land on the bank not being written.
  logic wr_bank_nxt;
  assign wr_bank_nxt = ~sdram_wr_addr[ADDR_W-1];
`endif

  sdram_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .ack      (sdram_wr_ack),
    .load     (wr_load),
    .idle     (st_idle),
    .wait_st  (state == S_WAIT_WR),
    .burst    (wr_burst),
    .min_addr (wr_min_addr),
    .max_addr (wr_max_addr),
`ifdef SDRAM_PINGPONG_EN
    .wrap_bank(wr_bank_nxt),
`endif
    .addr     (sdram_wr_addr),
    .pend     (wr_pend),
    .done     (wr_done)
  );

  sdram_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .ack      (sdram_rd_ack),
    .load     (rd_load),
    .idle     (st_idle),
    .wait_st  (state == S_WAIT_RD),
    .burst    (rd_burst),
    .min_addr (rd_min_addr),
    .max_addr (rd_max_addr),
`ifdef SDRAM_PINGPONG_EN
    .wrap_bank(wr_bank_nxt),
`endif
    .addr     (sdram_rd_addr),
    .pend     (rd_pend),
    .done     (rd_done)
  );

endmodule

// File: tb/tb_sdram_req_arb.sv
// Directed bench for sdram_req_arb: request decision table plus multi-cycle burst sequences.
module tb_sdram_req_arb;

  localparam int ADDR_W    = 24;
  localparam int LEN_W     = 10;
  localparam int USE_W     = 11;
  localparam int RDF_DEPTH = 1024;
`ifdef SDRAM_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sdram_init_done;
  logic [USE_W-1:0]  wrf_use, rdf_use;
  logic              rd_valid;
  logic [ADDR_W-1:0] wr_min_addr, wr_max_addr, rd_min_addr, rd_max_addr;
  logic [LEN_W-1:0]  wr_burst, rd_burst;
  logic              wr_load, rd_load, sdram_wr_ack, sdram_rd_ack;
  logic              sdram_wr_req, sdram_rd_req;
  logic [ADDR_W-1:0] sdram_wr_addr, sdram_rd_addr;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sdram_req_arb #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .USE_W(USE_W), .RDF_DEPTH(RDF_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(sdram_init_done),
    .wrf_use(wrf_use), .rdf_use(rdf_use), .rd_valid(rd_valid),
    .wr_min_addr(wr_min_addr), .wr_max_addr(wr_max_addr),
    .rd_min_addr(rd_min_addr), .rd_max_addr(rd_max_addr),
    .wr_burst(wr_burst), .rd_burst(rd_burst),
    .wr_load(wr_load), .rd_load(rd_load),
    .sdram_wr_ack(sdram_wr_ack), .sdram_rd_ack(sdram_rd_ack),
    .sdram_wr_req(sdram_wr_req), .sdram_rd_req(sdram_rd_req),
    .sdram_wr_addr(sdram_wr_addr), .sdram_rd_addr(sdram_rd_addr)
  );

  typedef struct {
    bit init;
    int wrf;
    int rdf;
    bit rdv;
    int wb;
    int rb;
    bit exp_wr;
    bit exp_rd;
  } vec_t;

  vec_t vt [12];

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    sdram_init_done = 1'b0;
    wrf_use = '0; rdf_use = '0; rd_valid = 1'b0;
    wr_min_addr = '0; wr_max_addr = 24'hFFFFFF;
    rd_min_addr = '0; rd_max_addr = 24'hFFFFFF;
    wr_burst = 10'd256; rd_burst = 10'd256;
    wr_load = 1'b0; rd_load = 1'b0;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic wait_req(input bit is_wr, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (is_wr ? sdram_wr_req : sdram_rd_req) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  // One complete burst handshake; stop clears wrf_use so no further write follows.
  task automatic burst(input bit is_wr, input int hold, input bit stop);
    bit ok;
    wait_req(is_wr, ok);
    chk(is_wr ? "wr_req_up" : "rd_req_up", 32'(ok), 32'd1);
    chk("one_hot", 32'(sdram_wr_req & sdram_rd_req), 32'd0);
    if (is_wr) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
    step(hold);
    chk(is_wr ? "wr_req_drop" : "rd_req_drop",
        32'(is_wr ? sdram_wr_req : sdram_rd_req), 32'd0);
    if (stop) wrf_use = '0;
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    step(1);
  endtask

  initial begin
    bit ok;
    //          init wrf  rdf  rdv wb   rb   wr rd
    vt[0]  = '{1'b0, 600, 0,   1'b0, 256, 256, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 600, 0,   1'b0, 256, 256, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 255, 0,   1'b0, 256, 256, 1'b0, 1'b0};
    vt[3]  = '{1'b1, 256, 0,   1'b0, 256, 256, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 300, 0,   1'b1, 256, 256, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 0,   800, 1'b1, 256, 256, 1'b0, 1'b0};
    vt[6]  = '{1'b1, 0,   768, 1'b1, 256, 256, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 0,   769, 1'b1, 256, 256, 1'b0, 1'b0};
    vt[8]  = '{1'b1, 0,   0,   1'b0, 256, 256, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 600, 0,   1'b0, 0,   256, 1'b0, 1'b0};
    vt[10] = '{1'b1, 0,   0,   1'b1, 256, 0,   1'b0, 1'b0};
    vt[11] = '{1'b0, 0,   0,   1'b1, 256, 256, 1'b0, 1'b0};

    do_reset();
    chk("rst_wr_req", 32'(sdram_wr_req), 32'd0);
    chk("rst_rd_req", 32'(sdram_rd_req), 32'd0);
    chk("rst_wr_addr", 32'(sdram_wr_addr), 32'd0);
    chk("rst_rd_addr", 32'(sdram_rd_addr), 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_reset();
      sdram_init_done = vt[i].init;
      wrf_use  = USE_W'(vt[i].wrf);
      rdf_use  = USE_W'(vt[i].rdf);
      rd_valid = vt[i].rdv;
      wr_burst = LEN_W'(vt[i].wb);
      rd_burst = LEN_W'(vt[i].rb);
      step(2);
      chk($sformatf("vec%0d_wr_req", i), 32'(sdram_wr_req), 32'(vt[i].exp_wr));
      chk($sformatf("vec%0d_rd_req", i), 32'(sdram_rd_req), 32'(vt[i].exp_rd));
    end

    // Write priority, long ack, then the read path gets its turn.
    do_reset();
    sdram_init_done = 1'b1;
    wrf_use = 11'd300; rd_valid = 1'b1; rdf_use = '0;
    wr_max_addr = 24'd768; rd_max_addr = 24'd512;
    step(2);
    chk("prio_wr_req", 32'(sdram_wr_req), 32'd1);
    chk("prio_rd_req", 32'(sdram_rd_req), 32'd0);
    sdram_wr_ack = 1'b1;
    step(260);
    chk("long_ack_req", 32'(sdram_wr_req), 32'd0);
    chk("long_ack_addr", 32'(sdram_wr_addr), 32'd0);
    wrf_use = '0;
    sdram_wr_ack = 1'b0;
    step(1);
    chk("long_ack_adv", 32'(sdram_wr_addr), 32'd256);
    burst(1'b0, 4, 1'b0);
    chk("rd_adv", 32'(sdram_rd_addr), 32'd256);

    // Window wrap over three bursts, then a read wrap.
    do_reset();
    sdram_init_done = 1'b1;
    wrf_use = 11'd300; wr_max_addr = 24'd768;
    burst(1'b1, 4, 1'b0);
    chk("wrap_a1", 32'(sdram_wr_addr), 32'd256);
    burst(1'b1, 4, 1'b0);
    chk("wrap_a2", 32'(sdram_wr_addr), 32'd512);
    burst(1'b1, 4, 1'b1);
    chk("wrap_a3", 32'(sdram_wr_addr), PP ? 32'h800000 : 32'd0);
    rd_valid = 1'b1; rdf_use = '0;
    rd_min_addr = 24'h10; rd_max_addr = 24'h100;
    burst(1'b0, 4, 1'b0);
    chk("rd_wrap", 32'(sdram_rd_addr), 32'h10);

    // Load edge during an active ack.
    do_reset();
    sdram_init_done = 1'b1;
    wrf_use = 11'd300;
    wr_min_addr = 24'h1000; wr_max_addr = 24'h100000;
    wait_req(1'b1, ok);
    chk("ld_req_up", 32'(ok), 32'd1);
    sdram_wr_ack = 1'b1;
    step(3);
    wr_load = 1'b1;
    step(3);
    chk("ld_hold1", 32'(sdram_wr_addr), 32'd0);
    wr_load = 1'b0;
    step(2);
    chk("ld_hold2", 32'(sdram_wr_addr), 32'd0);
    wrf_use = '0;
    sdram_wr_ack = 1'b0;
    step(1);
    chk("ld_next", 32'(sdram_wr_addr), 32'h1000);
    step(3);
    chk("ld_settled", 32'(sdram_wr_addr), 32'h1000);
    wrf_use = 11'd300;
    burst(1'b1, 4, 1'b0);
    chk("ld_after", 32'(sdram_wr_addr), 32'h1100);

    // Asynchronous reset while a request is outstanding.
    wait_req(1'b1, ok);
    chk("ar_req_up", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("ar_wr_req", 32'(sdram_wr_req), 32'd0);
    chk("ar_wr_addr", 32'(sdram_wr_addr), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);

    // Read load while idle.
    do_reset();
    rd_min_addr = 24'h40;
    rd_load = 1'b1;
    step(2);
    chk("rd_load", 32'(sdram_rd_addr), 32'h40);
    rd_load = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/sdram_req_arb.md
Name: sdram_req_arb

Overview:
- Upstream request arbiter and address generator for the SDRAM controller.
- Watches write-FIFO and read-FIFO fill levels and issues burst write/read requests. Holds each request until the controller acknowledges it.
- Advances burst start addresses on burst completion, wrapping within programmed frame windows.
- Sits between the LCD/scaler FIFOs and the SDRAM state controller; all inputs are synchronous to clk.

Parameters:
- ADDR_W, 24, SDRAM linear address width ({bank[1:0], row[12:0], col[8:0]}).
- LEN_W, 10, burst length width (1..512 words).
- USE_W, 11, FIFO fill-level width.
- RDF_DEPTH, 1024, read-FIFO depth in words.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sdram_init_done  in  1  controller initialisation complete
- wrf_use  in  USE_W  write-FIFO words available
- rdf_use  in  USE_W  read-FIFO words occupied
- rd_valid  in  1  read stream enabled
- wr_min_addr  in  ADDR_W  write window start
- wr_max_addr  in  ADDR_W  write window end (exclusive)
- rd_min_addr  in  ADDR_W  read window start
- rd_max_addr  in  ADDR_W  read window end (exclusive)
- wr_burst  in  LEN_W  write burst length
- rd_burst  in  LEN_W  read burst length
- wr_load  in  1  level; rising edge restarts write address
- rd_load  in  1  level; rising edge restarts read address
- sdram_wr_ack  in  1  controller write acknowledge (multi-cycle high)
- sdram_rd_ack  in  1  controller read acknowledge (multi-cycle high)
- sdram_wr_req  out  1  burst write request
- sdram_rd_req  out  1  burst read request
- sdram_wr_addr  out  ADDR_W  current write burst start address
- sdram_rd_addr  out  ADDR_W  current read burst start address

Interface: one clock (clk); reset is asynchronous and active-low (rst_n).

Behaviour:
- Reset values:
  - sdram_wr_req = 0, sdram_rd_req = 0.
  - sdram_wr_addr = 0, sdram_rd_addr = 0.
  - FSM in S_IDLE; edge registers and load-pending flags cleared.
- FSM states: S_IDLE, S_WR, S_WAIT_WR, S_RD, S_WAIT_RD.
- S_IDLE, evaluated only when sdram_init_done = 1 and no load is pending:
  - If wrf_use >= wr_burst: set sdram_wr_req the next cycle, go to S_WR.
  - Else if rd_valid and rdf_use <= RDF_DEPTH - rd_burst: set sdram_rd_req, go to S_RD.
  - Write has priority when both conditions are true in the same cycle.
- S_WR: hold sdram_wr_req high until sdram_wr_ack is sampled high, then drop the request the following cycle and go to S_WAIT_WR. The request is held indefinitely while the controller is busy refreshing.
- S_WAIT_WR: on the falling edge of sdram_wr_ack (registered previous = 1, current = 0):
  - next = sdram_wr_addr + wr_burst.
  - If next >= wr_max_addr, load wr_min_addr; otherwise load next.
  - Return to S_IDLE.
  - The address update is visible the cycle after the falling edge.
- S_RD / S_WAIT_RD: identical to the write path, using the read signals.
- Only one request is ever high at a time. Each completed burst advances its address exactly once.
- Load handling:
  - A rising edge on wr_load/rd_load sets its pending flag.
  - Pending flags are applied only in S_IDLE: address loads min_addr and the flag clears. This takes one cycle, during which no request is issued.
  - A load arriving mid-burst never alters the in-flight address; it is applied after that burst's address advance, overriding it.
- Arithmetic: ADDR_W-bit unsigned; wr_burst/rd_burst are zero-extended. The comparison uses an ADDR_W+1-bit sum so overflow still wraps correctly.
- wr_burst = 0 or rd_burst = 0 is illegal; the block issues no request for that path.
- rst_n asserted mid-burst: all outputs return to reset values immediately (asynchronous).

Optional Feature:
- Macro SDRAM_PINGPONG_EN.
- Defined:
  - Address MSB (bank[1]) is managed as a ping-pong bit.
  - On each write-window wrap, the write bank bit toggles.
  - On each read-window wrap, the read bank bit is set to the inverse of the current write bank bit, so reads never target the frame being written.
  - Window comparisons use address bits [ADDR_W-2:0] only.
- Undefined: the MSB is an ordinary address bit; plain linear wrap.

Decomposition:
- Package sdram_arb_pkg: FSM state encodings, ADDR_W/LEN_W defaults.
- One natural sub-module, sdram_addr_gen, instantiated twice (write and read). It contains ack falling-edge detection, load-pending flag, wrap logic and the ping-pong bit. The top level holds the arbitration FSM.

Test Plan:
- Hold init_done = 0 with wrf_use = 600, wr_burst = 256 -> no request ever. Raise init_done -> sdram_wr_req rises within 2 cycles.
- wrf_use = 300, rd_valid = 1, rdf_use = 0, both bursts 256 -> write request first. After ack high 260 cycles then low -> wr_addr = 256, then rd_req issues.
- wr_min = 0, wr_max = 768, burst 256, three completed bursts -> wr_addr sequence 256, 512, 0.
- wr_load rising edge during an active ack -> address unchanged until ack falls; next value is wr_min_addr (0x1000), not the incremented one.
- rdf_use = 800, RDF_DEPTH = 1024, rd_burst = 256 -> no rd_req. Drop rdf_use to 768 -> rd_req asserts.
- With SDRAM_PINGPONG_EN: write wraps once -> wr_addr MSB = 1. Subsequent read wrap -> rd_addr MSB = 0.
